// File: rtl/ip_tonegen.sv
// ip_tonegen: I/O-mapped square-wave tone generator. It drives ip_pwm with a 16-bit level
// and a ~1 MHz tick strobe. Software programs the period, volume and play duration.
module ip_tonegen #(
  parameter logic [7:0]  io_address = 8'h10,
  parameter logic [6:0]  clk_div    = 7'd54,
  parameter logic [13:0] ms10_ticks = 14'd9999
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] bus_address,
  output logic        bus_io_cs,
  output logic        bus_memory_cs,
  output logic        bus_read_ready,
  output logic [7:0]  bus_read_data,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic        bus_io,
  input  logic        bus_memory,
  output logic        tick,
  output logic [15:0] signal_level,
  output logic        playing
);

  logic [6:0]  prescaler;
  logic [15:0] period;
  logic [15:0] div_count;
  logic [7:0]  shadow_lo;
  logic [7:0]  volume;
  logic [7:0]  remaining;
  logic [13:0] sub10;
  logic        phase;
  logic        continuous;
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rd_mux;
  logic        unused_inputs;

  // Bus handshake: bus_read/bus_write are single-clock strobes qualified by bus_io_cs.
  // A read strobe is answered on the following clock by a one-clock bus_read_ready pulse
  // carrying the data; bus_read_data is 8'h00 whenever bus_read_ready is low, so the
  // fabric can OR this slave with the others. Writes complete on the strobe edge.
  assign bus_io_cs     = bus_io & (bus_address[7:2] == io_address[7:2]);
  assign bus_memory_cs = 1'b0;
  assign reg_sel       = bus_address[1:0];
  assign wr_en         = bus_write & bus_io_cs;
  assign rd_en         = bus_read & bus_io_cs;
  assign unused_inputs = ^{bus_memory, bus_address[15:8]};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      prescaler <= 7'd0;
      tick      <= 1'b0;
    end else if (prescaler == 7'd0) begin
      prescaler <= clk_div;
      tick      <= 1'b1;
    end else begin
      prescaler <= prescaler - 7'd1;
      tick      <= 1'b0;
    end
  end

  // Period commit is placed after the tick update so it wins on a shared edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      period    <= 16'd0;
      shadow_lo <= 8'd0;
      div_count <= 16'd0;
      phase     <= 1'b0;
    end else begin
      if (tick) begin
        if (div_count == 16'd0) begin
          div_count <= period;
          phase     <= (period != 16'd0) & ~phase;
        end else begin
          div_count <= div_count - 16'd1;
        end
      end
      if (wr_en && reg_sel == 2'd0) begin
        shadow_lo <= bus_write_data;
      end
      if (wr_en && reg_sel == 2'd1) begin
        period    <= {bus_write_data, shadow_lo};
        div_count <= {bus_write_data, shadow_lo};
        phase     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      volume <= 8'd0;
    end else if (wr_en && reg_sel == 2'd2) begin
      volume <= bus_write_data;
    end
  end

  // Duration counts 10 ms units; a control write on the expiry tick overrides the stop.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      playing    <= 1'b0;
      continuous <= 1'b0;
      remaining  <= 8'd0;
      sub10      <= 14'd0;
    end else begin
      if (tick && playing && !continuous) begin
        if (sub10 != 14'd0) begin
          sub10 <= sub10 - 14'd1;
        end else begin
          sub10 <= ms10_ticks;
          if (remaining != 8'd0) begin
            remaining <= remaining - 8'd1;
          end
          if (remaining <= 8'd1) begin
            playing <= 1'b0;
          end
        end
      end
      if (wr_en && reg_sel == 2'd3) begin
        if (bus_write_data == 8'h00) begin
          playing    <= 1'b0;
          continuous <= 1'b0;
        end else if (bus_write_data == 8'hFF) begin
          playing    <= 1'b1;
          continuous <= 1'b1;
        end else begin
          playing    <= 1'b1;
          continuous <= 1'b0;
          remaining  <= bus_write_data;
          sub10      <= ms10_ticks;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      signal_level <= 16'h0000;
    end else begin
      signal_level <= (playing && phase) ? {volume, 8'h00} : 16'h0000;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      2'd0:    rd_mux = period[7:0];
      2'd1:    rd_mux = period[15:8];
      2'd2:    rd_mux = volume;
      default: rd_mux = {6'd0, continuous, playing};
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus_read_ready <= 1'b0;
      bus_read_data  <= 8'h00;
    end else begin
      bus_read_ready <= rd_en;
      bus_read_data  <= rd_en ? rd_mux : 8'h00;
    end
  end

endmodule
